// File: rtl/m26_rx_line_deser_pkg.sv
// Shared types and constants for the Mimosa26 RX line deserializer.
package m26_rx_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned MKD_LEN = 4;
  localparam logic [MKD_LEN:0] MKD_PATTERN = 5'b01111;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    FCNT,
    LEN,
    DATA,
    TRAILER
  } state_e;

endpackage

// File: rtl/m26_rx_line_deser_if.sv
// Serial input / word output bundle of one Mimosa26 data line.
// FCNT_ERROR exists only when M26_RX_FCNT_CHECK_EN is defined.
interface m26_rx_line_deser_if;

  logic                          MKD_RX;
  logic                          DATA_RX;
  logic                          WRITE;
  logic                          FRAME_START;
  logic [m26_rx_pkg::WORD_W-1:0] DATA;
  logic                          LEN_ERROR;
  logic                          RESYNC_ERROR;
`ifdef M26_RX_FCNT_CHECK_EN
  logic                          FCNT_ERROR;
`endif

`ifdef M26_RX_FCNT_CHECK_EN
  modport master (
    output MKD_RX, DATA_RX,
    input  WRITE, FRAME_START, DATA, LEN_ERROR, RESYNC_ERROR, FCNT_ERROR
  );
  modport slave (
    input  MKD_RX, DATA_RX,
    output WRITE, FRAME_START, DATA, LEN_ERROR, RESYNC_ERROR, FCNT_ERROR
  );
`else
  modport master (
    output MKD_RX, DATA_RX,
    input  WRITE, FRAME_START, DATA, LEN_ERROR, RESYNC_ERROR
  );
  modport slave (
    input  MKD_RX, DATA_RX,
    output WRITE, FRAME_START, DATA, LEN_ERROR, RESYNC_ERROR
  );
`endif

endinterface

// File: rtl/m26_rx_line_deser_mkd_detect.sv
// Marker history and start-of-frame detect: fires once when the 4th
// consecutive MKD bit is sampled after a 0.
module m26_mkd_detect
  import m26_rx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mkd_i,
  output logic det_o
);

  // Only the last MKD_LEN bits are stored; the incoming bit completes the window.
  logic [MKD_LEN-1:0] mkd_sr_q;
  logic [MKD_LEN:0]   mkd_sr_d;

  assign mkd_sr_d = {mkd_sr_q, mkd_i};
  assign det_o    = (mkd_sr_d == MKD_PATTERN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mkd_sr_q <= '0;
    end else begin
      mkd_sr_q <= mkd_sr_d[MKD_LEN-1:0];
    end
  end

endmodule

// File: rtl/m26_rx_line_deser.sv
// Mimosa26 per-line deserializer: recovers 16-bit words and tracks the
// header/fcnt/len/data/trailer frame. Optional FCNT continuity check: M26_RX_FCNT_CHECK_EN.
module m26_rx_line_deser
  import m26_rx_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 570,
  parameter int unsigned CNT_W     = 10
)(
  input  logic                CLK_RX,
  input  logic                RST_N,
  m26_rx_line_deser_if.slave  bus
);

  localparam logic [WORD_W-1:0] MAX_LEN = WORD_W'(MAX_WORDS);

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0]   sr_q;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                write_q, write_d;
  logic                fs_q, fs_d;
  logic                len_err_q, len_err_d;
  logic                resync_q, resync_d;
  logic                mkd_det;
  logic                word_done;

  m26_mkd_detect u_mkd_detect (
    .clk_i  (CLK_RX),
    .rst_ni (RST_N),
    .mkd_i  (bus.MKD_RX),
    .det_o  (mkd_det)
  );

  // bit_cnt_q is the index of the bit held in sr_q[0]; 15 means sr_q is a full word.
  assign word_done = (state_q != IDLE) && (bit_cnt_q == 4'd15);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    data_d     = data_q;
    write_d    = 1'b0;
    fs_d       = 1'b0;
    len_err_d  = 1'b0;
    resync_d   = 1'b0;

    if (state_q != IDLE) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

    if (word_done) begin
      write_d = 1'b1;
      data_d  = sr_q;
      unique case (state_q)
        HEADER: begin
          state_d = FCNT;
          fs_d    = 1'b1;
        end
        FCNT: state_d = LEN;
        LEN: begin
          if (sr_q > MAX_LEN) begin
            len_err_d = 1'b1;
            state_d   = IDLE;
          end else if (sr_q == '0) begin
            state_d = TRAILER;
          end else begin
            word_cnt_d = CNT_W'(sr_q - 16'd1);
            state_d    = DATA;
          end
        end
        DATA: begin
          if (word_cnt_q == '0) begin
            state_d = TRAILER;
          end else begin
            word_cnt_d = word_cnt_q - CNT_W'(1);
          end
        end
        TRAILER: state_d = IDLE;
        default: ;
      endcase
    end

    // A marker landing exactly on trailer completion is a clean back-to-back frame.
    if (mkd_det) begin
      if ((state_q != IDLE) && !((state_q == TRAILER) && word_done)) begin
        resync_d = 1'b1;
      end
      state_d   = HEADER;
      bit_cnt_d = 4'd3;
    end
  end

  always_ff @(posedge CLK_RX or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sr_q       <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      fs_q       <= 1'b0;
      len_err_q  <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sr_q       <= {sr_q[WORD_W-2:0], bus.DATA_RX};
      data_q     <= data_d;
      write_q    <= write_d;
      fs_q       <= fs_d;
      len_err_q  <= len_err_d;
      resync_q   <= resync_d;
    end
  end

  assign bus.WRITE        = write_q;
  assign bus.FRAME_START  = fs_q;
  assign bus.DATA         = data_q;
  assign bus.LEN_ERROR    = len_err_q;
  assign bus.RESYNC_ERROR = resync_q;

`ifdef M26_RX_FCNT_CHECK_EN
  logic [WORD_W-1:0] fcnt_last_q, fcnt_last_d;
  logic              fcnt_vld_q, fcnt_vld_d;
  logic              fcnt_err_q, fcnt_err_d;

  always_comb begin
    fcnt_last_d = fcnt_last_q;
    fcnt_vld_d  = fcnt_vld_q;
    fcnt_err_d  = 1'b0;
    if (word_done && (state_q == FCNT)) begin
      fcnt_err_d  = fcnt_vld_q && (sr_q != fcnt_last_q + 16'd1);
      fcnt_last_d = sr_q;
      fcnt_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK_RX or negedge RST_N) begin
    if (!RST_N) begin
      fcnt_last_q <= '0;
      fcnt_vld_q  <= 1'b0;
      fcnt_err_q  <= 1'b0;
    end else begin
      fcnt_last_q <= fcnt_last_d;
      fcnt_vld_q  <= fcnt_vld_d;
      fcnt_err_q  <= fcnt_err_d;
    end
  end

  assign bus.FCNT_ERROR = fcnt_err_q;
`endif

endmodule

// File: doc/m26_rx_line_deser.md
Name: m26_rx_line_deser

Overview:
- Per-line deserializer and frame tracker for the Mimosa26 serial output.
- Takes one registered data bit per CLK_RX plus the MKD marker bit, recovers 16-bit words, and walks the frame structure: header, frame counter, data length, data words, trailer.
- Emits one WRITE strobe per word with FRAME_START on the header word.
- Sits directly upstream of the M26 RX core merge/CDC stage; two instances per sensor, one per data line.

Parameters:
- MAX_WORDS, 570: largest legal data-length field value; larger values abort the frame.
- CNT_W, 10: width of the internal data-word counter; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- CLK_RX  input  1  serial bit clock; all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- MKD_RX  input  1  frame marker bit, already registered and aligned to DATA_RX.
- DATA_RX  input  1  serial data bit, MSB-first per word.
- WRITE  output  1  one-cycle strobe; DATA holds a valid word.
- FRAME_START  output  1  high together with WRITE for the header word only.
- DATA  output  16  recovered word.
- LEN_ERROR  output  1  one-cycle pulse; data-length field exceeds MAX_WORDS.
- RESYNC_ERROR  output  1  one-cycle pulse; marker seen while a frame is in progress.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, shift register 0.
- Shift register `sr[15:0]` updates every cycle: `sr <= {sr[14:0], DATA_RX}`.
- Marker history `mkd_sr[4:0] <= {mkd_sr[3:0], MKD_RX}`.
- Marker detect: next value of `mkd_sr == 5'b01111`, i.e. the 4th consecutive 1 is being sampled and the bit before the run was 0.
  - The 4 marker bits coincide with the first 4 header bits.
  - On detect: bit_cnt <= 3, state <= HEADER.
  - A run of 5 or more ones fires only once.
- bit_cnt counts 0..15 and wraps.
- Word complete: bit_cnt == 15 in any state other than IDLE.
  - On the next cycle: DATA <= sr (including the current bit) and WRITE = 1.
  - Latency: WRITE is asserted 1 cycle after the 16th bit is sampled.
- States and transitions (each taken on word complete):
  - HEADER -> FCNT, with FRAME_START = 1.
  - FCNT -> LEN.
  - LEN: latch len = word.
    - len > MAX_WORDS: write the word, pulse LEN_ERROR, go to IDLE.
    - len == 0: go to TRAILER.
    - otherwise: word_cnt <= len-1, go to DATA.
  - DATA: if word_cnt == 0 go to TRAILER, else decrement word_cnt.
  - TRAILER -> IDLE.
- IDLE: no WRITE, bit_cnt frozen, only marker detect active.
- Marker detect in a non-IDLE state, other than the cycle that completes the trailer word:
  - pulse RESYNC_ERROR;
  - any word completing in that same cycle is still written;
  - then restart at HEADER with bit_cnt = 3.
- WRITE and FRAME_START never assert outside a frame. FRAME_START is never high without WRITE.
- Asynchronous reset mid-frame returns to IDLE immediately. No partial word is emitted.

Optional Feature:
- Macro: M26_RX_FCNT_CHECK_EN.
- Defined:
  - Keeps a 16-bit copy of the last FCNT word plus a valid flag.
  - Adds output FCNT_ERROR (1 bit, reset 0). It pulses together with the WRITE of the FCNT word when valid == 1 and the word != last+1 (modulo 2^16; 0xFFFF -> 0x0000 is legal).
  - The first frame after reset only loads the copy.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package `m26_rx_pkg`:
  - state enum {IDLE, HEADER, FCNT, LEN, DATA, TRAILER};
  - WORD_W = 16; MKD_LEN = 4; MKD_PATTERN = 5'b01111.
- One natural sub-module, `m26_mkd_detect`: marker history register and detect pulse. Reused by the sibling line instance.

Test Plan:
- Reset then idle stream of random DATA_RX with MKD_RX = 0 for 200 cycles -> no WRITE, all outputs 0.
- Marker 4 cycles, frame header 0x5555, fcnt 0x0001, len 3, data 0xA001/0xA002/0xA003, trailer 0xAAAA -> exactly 7 WRITEs in that order.
  - FRAME_START only on 0x5555.
  - First WRITE 13 cycles after the 4th marker bit.
- len = 0 -> 4 WRITEs (header, fcnt, 0x0000, trailer), then IDLE.
- len = 571 with MAX_WORDS = 570 -> 3 WRITEs, LEN_ERROR pulses with the len write, no further WRITE until the next marker.
- Second marker inserted during a DATA word -> RESYNC_ERROR one pulse, next WRITE is the new header with FRAME_START; a 5-cycle-long marker yields a single detect.
- With M26_RX_FCNT_CHECK_EN defined, consecutive frames with fcnt 0xFFFF, 0x0000, 0x0002 -> FCNT_ERROR only on 0x0002. Assert RST_N low mid-frame -> outputs 0 within the same cycle.
